// File: rtl/fetch_pc_gen_if.sv
// fetch_pc_gen_if: fetch-group handshake and redirect bus between the PC generator and its neighbours.
interface fetch_pc_gen_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int FETCH_WIDTH = 2,
  parameter int EPOCH_WIDTH = 3
);
  logic                   fetch_ready;
  logic                   exception_taken;
  logic [ADDR_WIDTH-1:0]  exception_address;
  logic                   branch_taken;
  logic [ADDR_WIDTH-1:0]  branch_address;
  logic                   fetch_valid;
  logic [ADDR_WIDTH-1:0]  fetch_pc;
  logic [FETCH_WIDTH-1:0] fetch_mask;
  logic                   fetch_misaligned;
  logic [EPOCH_WIDTH-1:0] fetch_epoch;
  modport master (
    input  fetch_ready, exception_taken, exception_address, branch_taken, branch_address,
    output fetch_valid, fetch_pc, fetch_mask, fetch_misaligned, fetch_epoch
  );
  modport slave (
    output fetch_ready, exception_taken, exception_address, branch_taken, branch_address,
    input  fetch_valid, fetch_pc, fetch_mask, fetch_misaligned, fetch_epoch
  );
endinterface

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: aligned fetch-group address generator with prioritised redirects and epoch tagging.
module fetch_pc_gen #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    FETCH_WIDTH  = 2,
  parameter int                    INST_BYTES   = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 32'hbfc0_0000,
  parameter int                    EPOCH_WIDTH  = 3
) (
  input logic            clk,
  input logic            rst_n,
  fetch_pc_gen_if.master bus
);
  localparam int G  = FETCH_WIDTH * INST_BYTES;
  localparam int IB = $clog2(INST_BYTES);
  typedef enum logic [1:0] {BOOT, RUN, FAULT} state_t;
  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d, base, off;
  logic [EPOCH_WIDTH-1:0] epoch_q, epoch_d;
  logic                   redir, accept, mis;
  always_comb begin
    redir   = bus.exception_taken | bus.branch_taken;
    mis     = (pc_q & ADDR_WIDTH'(INST_BYTES - 1)) != '0;
    accept  = state_q == RUN && bus.fetch_ready;
    base    = pc_q & ~ADDR_WIDTH'(G - 1);
    off     = (pc_q & ADDR_WIDTH'(G - 1)) >> IB;
    state_d = (redir || state_q == BOOT) ? RUN : (accept && mis) ? FAULT : state_q;
    pc_d    = redir ? (bus.exception_taken ? bus.exception_address : bus.branch_address)
            : (accept && !mis) ? base + ADDR_WIDTH'(G) : pc_q;
    epoch_d = epoch_q + EPOCH_WIDTH'(redir);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
      epoch_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epoch_q <= epoch_d;
    end
  assign bus.fetch_valid      = state_q == RUN;
  assign bus.fetch_pc         = pc_q;
  assign bus.fetch_misaligned = mis;
  assign bus.fetch_epoch      = epoch_q;
  for (genvar i = 0; i < FETCH_WIDTH; i++) begin : g_mask
    assign bus.fetch_mask[i] = !mis && ADDR_WIDTH'(i) >= off;
  end
endmodule

// File: tb/tb_fetch_pc_gen.sv
// tb_fetch_pc_gen: directed vector table plus randomized run against a group-level reference model.
module tb_fetch_pc_gen;
  localparam int FW = 2, IB = 4, G = FW * IB, EW = 2;
  localparam logic [31:0] RV = 32'hbfc0_0000;
  localparam int S_BOOT = 0, S_RUN = 1, S_FAULT = 2;

  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;

  fetch_pc_gen_if #(.ADDR_WIDTH(32), .FETCH_WIDTH(FW), .EPOCH_WIDTH(EW)) bus ();
  fetch_pc_gen #(.ADDR_WIDTH(32), .FETCH_WIDTH(FW), .INST_BYTES(IB), .RESET_VECTOR(RV),
                 .EPOCH_WIDTH(EW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic        ready, exc;
    logic [31:0] ea;
    logic        br;
    logic [31:0] ba;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [1:0]  e_mask;
    logic        e_mis;
    logic [1:0]  e_ep;
  } vec_t;

  int checks = 0, failures = 0;
  int m_st, m_ep;
  logic [31:0] m_pc;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(string tag, logic v, logic [31:0] pc, logic [1:0] mask, logic mis, logic [1:0] ep);
    chk({tag, ".valid"}, 32'(bus.fetch_valid), 32'(v));
    chk({tag, ".pc"}, bus.fetch_pc, pc);
    chk({tag, ".mask"}, 32'(bus.fetch_mask), 32'(mask));
    chk({tag, ".mis"}, 32'(bus.fetch_misaligned), 32'(mis));
    chk({tag, ".epoch"}, 32'(bus.fetch_epoch), 32'(ep));
  endtask

  function automatic logic [1:0] model_mask(logic [31:0] pc);
    logic [1:0] m = '0;
    for (int i = 0; i < FW; i++) m[i] = (pc % IB == 0) && (i >= (pc % G) / IB);
    return m;
  endfunction

  task automatic model_reset();
    m_st = S_BOOT; m_pc = RV; m_ep = 0;
  endtask

  task automatic model_check(string tag);
    check_all(tag, m_st == S_RUN, m_pc, model_mask(m_pc), m_pc % IB != 0, 2'(m_ep));
  endtask

  // Apply one cycle of inputs, advance the model by the group-level rules, sample 1 ns after the edge.
  task automatic step(logic ready, logic exc, logic [31:0] ea, logic br, logic [31:0] ba);
    bus.fetch_ready = ready; bus.exception_taken = exc; bus.exception_address = ea;
    bus.branch_taken = br; bus.branch_address = ba;
    @(posedge clk);
    if (exc || br) begin
      m_pc = exc ? ea : ba; m_ep = (m_ep + 1) % (1 << EW); m_st = S_RUN;
    end else if (m_st == S_BOOT) m_st = S_RUN;
    else if (m_st == S_RUN && ready) begin
      if (m_pc % IB != 0) m_st = S_FAULT;
      else m_pc = 32'((longint'(m_pc) / G) * G + G);
    end
    #1;
  endtask

  task automatic pulse_reset(string tag);
    #2 rst_n = 0;
    model_reset();
    #1 check_all(tag, 1'b0, RV, 2'b11, 1'b0, 2'd0);
    @(negedge clk) rst_n = 1;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] r = $urandom;
    case ($urandom_range(0, 3))
      0: return r & ~32'h3;
      1: return (r & ~32'h3) | 32'($urandom_range(1, 3));
      2: return 32'hffff_fff0 + 32'(4 * $urandom_range(0, 3));
      default: return r & ~32'h7;
    endcase
  endfunction

  vec_t tv[$];

  initial begin
    tv.push_back('{1, 0, 0, 0, 0, 1, 32'hbfc00000, 2'b11, 0, 0});
    tv.push_back('{1, 0, 0, 0, 0, 1, 32'hbfc00008, 2'b11, 0, 0});
    tv.push_back('{0, 0, 0, 0, 0, 1, 32'hbfc00008, 2'b11, 0, 0});
    tv.push_back('{0, 0, 0, 0, 0, 1, 32'hbfc00008, 2'b11, 0, 0});
    tv.push_back('{0, 0, 0, 0, 0, 1, 32'hbfc00008, 2'b11, 0, 0});
    tv.push_back('{1, 0, 0, 0, 0, 1, 32'hbfc00010, 2'b11, 0, 0});
    tv.push_back('{0, 0, 32'h1111, 1, 32'h80000004, 1, 32'h80000004, 2'b10, 0, 1});
    tv.push_back('{1, 0, 0, 0, 32'hdead0000, 1, 32'h80000008, 2'b11, 0, 1});
    tv.push_back('{1, 1, 32'hbfc00380, 1, 32'h80001000, 1, 32'hbfc00380, 2'b11, 0, 2});
    tv.push_back('{0, 0, 0, 1, 32'h80000002, 1, 32'h80000002, 2'b00, 1, 3});
    tv.push_back('{1, 0, 0, 0, 0, 0, 32'h80000002, 2'b00, 1, 3});
    for (int k = 0; k < 5; k++) tv.push_back('{1, 0, 0, 0, 0, 0, 32'h80000002, 2'b00, 1, 3});
    tv.push_back('{1, 0, 0, 1, 32'h80000000, 1, 32'h80000000, 2'b11, 0, 0});
    tv.push_back('{0, 0, 0, 1, 32'hfffffff8, 1, 32'hfffffff8, 2'b11, 0, 1});
    tv.push_back('{1, 0, 0, 0, 0, 1, 32'h00000000, 2'b11, 0, 1});
    tv.push_back('{0, 0, 0, 0, 0, 1, 32'h00000000, 2'b11, 0, 1});

    bus.fetch_ready = 0; bus.exception_taken = 0; bus.exception_address = 0;
    bus.branch_taken = 0; bus.branch_address = 0;
    model_reset();
    #12 check_all("reset", 1'b0, RV, 2'b11, 1'b0, 2'd0);
    @(negedge clk) rst_n = 1;
    for (int k = 0; k < tv.size(); k++) begin
      step(tv[k].ready, tv[k].exc, tv[k].ea, tv[k].br, tv[k].ba);
      check_all($sformatf("vec%0d", k), tv[k].e_valid, tv[k].e_pc, tv[k].e_mask, tv[k].e_mis, tv[k].e_ep);
    end
    pulse_reset("async_rst_stall");
    step(1, 0, 0, 1, 32'h4000_0004);
    check_all("boot_redirect", 1'b1, 32'h4000_0004, 2'b10, 1'b0, 2'd1);

    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 49) == 0) pulse_reset($sformatf("rnd_rst%0d", k));
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0, rand_addr(),
           $urandom_range(0, 5) == 0, rand_addr());
      model_check($sformatf("rnd%0d", k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
